// File: rtl/uart_fifo_core_if.sv
// Interface carrying every UART/FIFO signal except clock and reset.
// master = user side driving the core, slave = the core itself.
interface uart_fifo_core_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DIV_WIDTH-1:0] Baud_Div;
    logic [1:0]           Parity_Mode;
    logic                 Loopback;
    logic [DATA_BITS-1:0] Tx_Data;
    logic                 Tx_Valid;
    logic                 Tx_Ready;
    logic                 CTS;
    logic                 Tx;
    logic                 Tx_Busy;
    logic                 Rx;
    logic [DATA_BITS-1:0] Rx_Data;
    logic                 Rx_Valid;
    logic                 Rx_Pop;
    logic [CNT_W-1:0]     FIFO_Count;
    logic                 RTS;
    logic                 FIFO_Overflow;
    logic                 Frame_Error;
    logic                 Parity_Error;

    modport master (
        output Baud_Div, Parity_Mode, Loopback, Tx_Data, Tx_Valid, CTS, Rx, Rx_Pop,
        input  Tx_Ready, Tx, Tx_Busy, Rx_Data, Rx_Valid, FIFO_Count, RTS,
               FIFO_Overflow, Frame_Error, Parity_Error
    );

    modport slave (
        input  Baud_Div, Parity_Mode, Loopback, Tx_Data, Tx_Valid, CTS, Rx, Rx_Pop,
        output Tx_Ready, Tx, Tx_Busy, Rx_Data, Rx_Valid, FIFO_Count, RTS,
               FIFO_Overflow, Frame_Error, Parity_Error
    );
endinterface

// File: rtl/uart_fifo_core.sv
// UART transmitter and receiver (16x oversampling) with a show-ahead RX FIFO.
// Define UART_PARITY_EN to enable the parity bit; without it Parity_Mode is ignored.
module uart_fifo_core #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input logic SysClk,
    input logic Rst,
    uart_fifo_core_if.slave bus
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t tx_state, tx_next, rx_state, rx_next;

`ifdef UART_PARITY_EN
    logic par_on, par_odd;
    assign par_on  = (bus.Parity_Mode == 2'b01) || (bus.Parity_Mode == 2'b10);
    assign par_odd = (bus.Parity_Mode == 2'b10);
`else
    logic unused_mode;
    assign unused_mode      = ^bus.Parity_Mode;
    assign bus.Parity_Error = 1'b0;
`endif

    // Divisor is frozen while either direction is mid-frame.
    logic [DIV_WIDTH-1:0] div_q;
    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst)
            div_q <= '0;
        else if (tx_state == IDLE && rx_state == IDLE)
            div_q <= bus.Baud_Div;
    end

    logic [DIV_WIDTH-1:0] tx_pre;
    logic [3:0]           tx_tick;
    logic [BIT_W-1:0]     tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_go, tx_tick_en, tx_bit_end, tx_bit;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign bus.Tx_Ready = !Rst && (tx_state == IDLE) && bus.CTS;
    assign bus.Tx_Busy  = (tx_state != IDLE);
    assign bus.Tx       = bus.Loopback ? 1'b1 : tx_bit;
    assign tx_go        = bus.Tx_Valid && bus.Tx_Ready;
    assign tx_tick_en   = (tx_pre == div_q);
    assign tx_bit_end   = tx_tick_en && (tx_tick == 4'd15);

    always_comb begin
        tx_next = tx_state;
        tx_bit  = 1'b1;
        case (tx_state)
            IDLE:  if (tx_go) tx_next = START;
            START: begin
                tx_bit = 1'b0;
                if (tx_bit_end) tx_next = DATA;
            end
            DATA: begin
                tx_bit = tx_shift[0];
                if (tx_bit_end && tx_idx == BIT_W'(DATA_BITS-1)) begin
`ifdef UART_PARITY_EN
                    tx_next = par_on ? PARITY : STOP;
`else
                    tx_next = STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                tx_bit = tx_par;
                if (tx_bit_end) tx_next = STOP;
            end
`endif
            STOP:  if (tx_bit_end && tx_idx == BIT_W'(STOP_BITS-1)) tx_next = IDLE;
            default: tx_next = IDLE;
        endcase
    end

    // tx_idx counts data bits in DATA and stop bits in STOP; it clears on every state change.
    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            tx_state <= IDLE;
            tx_pre   <= '0;
            tx_tick  <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_next;
            if (tx_state == IDLE) begin
                tx_pre  <= '0;
                tx_tick <= '0;
                tx_idx  <= '0;
                if (tx_go) begin
                    tx_shift <= bus.Tx_Data;
`ifdef UART_PARITY_EN
                    tx_par   <= (^bus.Tx_Data) ^ par_odd;
`endif
                end
            end else begin
                tx_pre <= tx_tick_en ? '0 : tx_pre + 1'b1;
                if (tx_tick_en) tx_tick <= tx_tick + 1'b1;
                if (tx_bit_end) begin
                    tx_idx <= (tx_next != tx_state) ? '0 : tx_idx + 1'b1;
                    if (tx_state == DATA) tx_shift <= tx_shift >> 1;
                end
            end
        end
    end

    logic                 rx_in, rx_s1, rx_s2, rx_s3, rx_fall;
    logic [DIV_WIDTH-1:0] rx_pre;
    logic [3:0]           rx_tick;
    logic [BIT_W-1:0]     rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_tick_en, rx_mid, rx_sample, fifo_wr, frame_err;
`ifdef UART_PARITY_EN
    logic                 rx_par_bad, par_err;
    assign bus.Parity_Error = par_err;
`endif

    assign rx_in           = bus.Loopback ? tx_bit : bus.Rx;
    assign rx_fall         = rx_s3 && !rx_s2;
    assign rx_tick_en      = (rx_pre == div_q);
    assign rx_mid          = rx_tick_en && (rx_tick == 4'd7);
    assign rx_sample       = rx_tick_en && (rx_tick == 4'd15);
    assign bus.Frame_Error = frame_err;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:  if (rx_fall) rx_next = START;
            START: if (rx_mid) rx_next = rx_s2 ? IDLE : DATA;
            DATA: begin
                if (rx_sample && rx_idx == BIT_W'(DATA_BITS-1)) begin
`ifdef UART_PARITY_EN
                    rx_next = par_on ? PARITY : STOP;
`else
                    rx_next = STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            PARITY: if (rx_sample) rx_next = STOP;
`endif
            STOP:  if (rx_sample) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    // After the START mid-point the tick counter restarts so later samples land mid-bit.
    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_s3      <= 1'b1;
            rx_state   <= IDLE;
            rx_pre     <= '0;
            rx_tick    <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            fifo_wr    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
            par_err    <= 1'b0;
`endif
        end else begin
            rx_s1     <= rx_in;
            rx_s2     <= rx_s1;
            rx_s3     <= rx_s2;
            rx_state  <= rx_next;
            fifo_wr   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            par_err   <= 1'b0;
`endif
            if (rx_state == IDLE) begin
                rx_pre  <= '0;
                rx_tick <= '0;
                rx_idx  <= '0;
`ifdef UART_PARITY_EN
                rx_par_bad <= 1'b0;
`endif
            end else begin
                rx_pre <= rx_tick_en ? '0 : rx_pre + 1'b1;
                if (rx_state == START && rx_mid)
                    rx_tick <= '0;
                else if (rx_tick_en)
                    rx_tick <= rx_tick + 1'b1;
                if (rx_sample) begin
                    case (rx_state)
                        DATA: begin
                            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                            rx_idx   <= rx_idx + 1'b1;
                        end
`ifdef UART_PARITY_EN
                        PARITY: rx_par_bad <= (rx_s2 != ((^rx_shift) ^ par_odd));
                        STOP: begin
                            if (!rx_s2)          frame_err <= 1'b1;
                            else if (rx_par_bad) par_err   <= 1'b1;
                            else                 fifo_wr   <= 1'b1;
                        end
`else
                        STOP: begin
                            if (!rx_s2) frame_err <= 1'b1;
                            else        fifo_wr   <= 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 overflow, empty, full, do_pop, do_push;

    assign empty             = (count == '0);
    assign full              = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop            = bus.Rx_Pop && !empty;
    assign do_push           = fifo_wr && (!full || do_pop);
    assign bus.Rx_Data       = empty ? '0 : mem[rd_ptr];
    assign bus.Rx_Valid      = !empty;
    assign bus.FIFO_Count    = count;
    assign bus.RTS           = (count <= CNT_W'(FIFO_DEPTH-2));
    assign bus.FIFO_Overflow = overflow;

    always_ff @(posedge SysClk) begin
        if (do_push) mem[wr_ptr] <= rx_shift;
    end

    // A pop in the same cycle frees the slot, so a write at full is then accepted.
    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
            if (fifo_wr && full && !do_pop) overflow <= 1'b1;
        end
    end
endmodule

// File: doc/uart_fifo_core.md
UART_FIFO_CORE -- requirements
Module: uart_fifo_core

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, RX FIFO entries; power of two, 2..256.
REQ-004 SHALL have parameter DIV_WIDTH, default 16, width of the Baud_Div port.
REQ-005 SHALL have ports:
  SysClk  in  1  single clock.
  Rst  in  1  asynchronous, active-high reset.
  Baud_Div  in  DIV_WIDTH  oversample tick period minus one.
  Parity_Mode  in  2  00 none, 01 even, 10 odd, 11 none.
  Loopback  in  1  internal Tx-to-Rx loop.
  Tx_Data  in  DATA_BITS  word to send.
  Tx_Valid  in  1  Tx_Data valid.
  Tx_Ready  out  1  transmitter can accept.
  CTS  in  1  clear-to-send, active-high.
  Tx  out  1  serial out, idle high.
  Tx_Busy  out  1  frame in progress.
  Rx  in  1  serial in, asynchronous.
  Rx_Data  out  DATA_BITS  FIFO head word.
  Rx_Valid  out  1  FIFO not empty.
  Rx_Pop  in  1  consume head word.
  FIFO_Count  out  clog2(FIFO_DEPTH)+1  occupancy.
  RTS  out  1  high while FIFO_Count <= FIFO_DEPTH-2.
  FIFO_Overflow  out  1  sticky overflow flag.
  Frame_Error  out  1  one-cycle pulse.
  Parity_Error  out  1  one-cycle pulse.

Function
REQ-006 SHALL generate an oversample tick every Baud_Div+1 SysClk cycles; Baud_Div=0 gives a tick every cycle; bit period = 16 ticks.
REQ-007 SHALL sample Baud_Div only while TX and RX FSMs are both IDLE; changes mid-frame take effect at the next IDLE.
REQ-008 TX FSM states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when Parity_Mode is 00 or 11.
REQ-009 Tx_Ready SHALL be 1 only in IDLE with CTS=1; transfer occurs on a cycle with Tx_Valid && Tx_Ready.
REQ-010 On transfer: Tx_Data latched; START entered on the next cycle; bit-timing restarts; each bit held exactly 16 ticks.
REQ-011 Bit order: start (0), data LSB first, optional parity, then STOP_BITS stop bits (1).
REQ-012 Parity bit: even = XOR of data bits; odd = its inverse.
REQ-013 Tx_Busy SHALL be 1 from START entry through the final stop tick; CTS deassertion mid-frame does not abort the frame.
REQ-014 Rx SHALL pass through a two-flop synchroniser; in Loopback=1, RX takes the internal TX bit and the Tx pin is forced to 1.
REQ-015 RX FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 A synchronised falling edge in IDLE enters START; at tick 8 the line is resampled; 1 = glitch, return to IDLE without flags.
REQ-017 RX SHALL sample data, parity and first stop bit every 16 ticks after the START mid-point; only the first stop bit is checked.
REQ-018 Stop sample 0 SHALL pulse Frame_Error and discard the word.
REQ-019 Parity mismatch SHALL pulse Parity_Error and discard the word.
REQ-020 A good word SHALL be written to the FIFO on the cycle after the stop sample; RX returns to IDLE in that cycle.
REQ-021 FIFO SHALL be show-ahead: Rx_Data = head, Rx_Valid = (FIFO_Count != 0); Rx_Pop while empty is ignored.
REQ-022 Write while full without a same-cycle pop SHALL drop the word and set FIFO_Overflow until Rst.
REQ-023 Simultaneous pop and write while full SHALL accept both; count is unchanged and no overflow occurs.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-025 Rst SHALL asynchronously force: Tx=1, Tx_Ready=0, Tx_Busy=0, Rx_Valid=0, Rx_Data=0, FIFO_Count=0, RTS=1, FIFO_Overflow=0, Frame_Error=0, Parity_Error=0; FSMs go to IDLE and tick counters clear.
REQ-026 Rst mid-frame SHALL abort both frames; Tx_Ready=1 on the first cycle after release if CTS=1.

Configuration
REQ-027 With macro UART_PARITY_EN defined, parity SHALL operate per REQ-008/012/019.
REQ-028 Without UART_PARITY_EN, Parity_Mode SHALL be ignored, the PARITY state omitted, and Parity_Error tied to 0.

Verification
REQ-029 Baud_Div=3, 8N1, Tx_Data=0xA5 -> Tx: 0,1,0,1,0,0,1,0,1,1, each bit 64 cycles; Tx_Busy high for 640 cycles.
REQ-030 Loopback=1, even parity, send 0x3C -> Rx_Valid=1, Rx_Data=0x3C, Parity_Error=0; Tx pin stays 1 throughout.
REQ-031 Drive an Rx frame with odd parity on an even-parity config -> Parity_Error pulse, FIFO_Count stays 0.
REQ-032 Drive an Rx frame with stop bit 0 -> Frame_Error pulse, no write; a 0.25-bit low glitch -> no flags, RX returns to IDLE.
REQ-033 FIFO_DEPTH=4: receive 5 words with no pops -> FIFO_Count=4, FIFO_Overflow=1, RTS=0 from count 3; pop-and-write at full -> count stays 4, no new overflow.
REQ-034 Assert Rst at data bit 3 of a TX frame -> Tx=1 immediately, FIFO_Count=0; after release a new frame transmits correctly.
